// File: rtl/vram_write_buffer.sv
// CPU-to-VRAM write buffer: first-word-fall-through FIFO that queues CPU byte writes,
// drains them while video timing reports writable, and merges repeat writes to the newest address.
module vram_write_buffer #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    output logic              cpu_ready,
    input  logic              writable,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_data,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    input  logic              clr_overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [7:0]        data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [LVL_W-1:0]  lvl;
    logic              ovf;
    logic              empty;
    logic              full;
    logic              pop;
    logic              tail_pop;
    logic              coalesce;
    logic              push;
    logic              drop;

    assign empty    = (lvl == '0);
    assign full     = (lvl == LVL_W'(DEPTH));
    assign tail_ptr = wr_ptr - 1'b1;

    assign pop      = writable & ~empty;
    // A tail that is leaving this cycle cannot absorb new data; the write becomes a normal push.
    assign tail_pop = pop & (lvl == LVL_W'(1));
    assign coalesce = cpu_wr & ~empty & ~tail_pop & (cpu_addr == addr_mem[tail_ptr]);
    assign push     = cpu_wr & ~full & ~coalesce;
    assign drop     = cpu_wr & full & ~coalesce;

    assign cpu_ready = ~full;
    assign vram_we   = pop;
    assign vram_addr = addr_mem[rd_ptr];
    assign vram_data = data_mem[rd_ptr];
    assign level     = lvl;
    assign overflow  = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                addr_mem[wr_ptr] <= cpu_addr;
                data_mem[wr_ptr] <= cpu_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end else if (coalesce) begin
                data_mem[tail_ptr] <= cpu_data;
            end
            lvl <= lvl + LVL_W'(push) - LVL_W'(pop);
            // A fresh drop outranks a simultaneous clear.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_overflow) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vram_write_buffer.sv
// Directed bench for vram_write_buffer with a queue-based reference model of the FIFO,
// coalescing and overflow behaviour, checked every cycle on the falling edge.
module tb_vram_write_buffer;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_wr = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [7:0]        cpu_data = '0;
    logic              cpu_ready;
    logic              writable = 1'b0;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_data;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              clr_overflow = 1'b0;

    vram_write_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ready(cpu_ready), .writable(writable), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_data(vram_data), .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #40 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } ent_t;

    ent_t q[$];
    bit   exp_ovf = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   drained = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model at negedge, then advance the model.
    task automatic cyc(input bit wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                       input bit wrb, input bit clr);
        bit   exp_we, tail_pop, coal, ready, drop;
        ent_t e;
        cpu_wr = wr; cpu_addr = a; cpu_data = d; writable = wrb; clr_overflow = clr;
        @(negedge clk);
        exp_we = wrb && (q.size() != 0);
        check("vram_we", vram_we, exp_we);
        check("level", level, q.size());
        check("cpu_ready", cpu_ready, q.size() != DEPTH);
        check("overflow", overflow, exp_ovf);
        if (exp_we) begin
            check("vram_addr", vram_addr, q[0].a);
            check("vram_data", vram_data, q[0].d);
            drained++;
        end
        tail_pop = exp_we && (q.size() == 1);
        coal  = wr && (q.size() != 0) && (q[$].a == a) && !tail_pop;
        ready = (q.size() != DEPTH);
        drop  = wr && !ready && !coal;
        if (exp_we) void'(q.pop_front());
        if (coal) q[$].d = d;
        else if (wr && ready) begin
            e.a = a; e.d = d;
            q.push_back(e);
        end
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit wrb);
        rst = 1'b1; cpu_wr = 1'b0; writable = wrb; clr_overflow = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        do_reset(1'b0);
        @(negedge clk);
        check("rst_level", level, 0);
        check("rst_we", vram_we, 0);
        check("rst_ready", cpu_ready, 1);
        check("rst_ovf", overflow, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_data", vram_data, 0);
        @(posedge clk);
        #1;

        // In-order drain of three queued writes.
        cyc(1, 12'h010, 8'hAA, 0, 0);
        cyc(1, 12'h011, 8'hBB, 0, 0);
        cyc(1, 12'h012, 8'hCC, 0, 0);
        cyc(0, 0, 0, 0, 0);
        drained = 0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        check("t1_drained", drained, 3);

        // Single write while writable: appears the following cycle only.
        cyc(1, 12'h100, 8'h55, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Coalescing of back-to-back same-address writes.
        cyc(1, 12'h020, 8'h01, 0, 0);
        cyc(1, 12'h020, 8'h02, 0, 0);
        cyc(1, 12'h021, 8'h03, 0, 0);
        cyc(1, 12'h020, 8'h04, 0, 0);
        check("t3_level", q.size(), 3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);

        // Fill to full, drop, coalesce while full, drop+clear together, then clear.
        for (int i = 0; i < 17; i++) cyc(1, 12'h200 + ADDR_W'(i), 8'(i + 1), 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 12'h20F, 8'hEE, 0, 0);
        cyc(1, 12'h3FF, 8'h77, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        drained = 0;
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 1, 0);
        check("t4_drained", drained, 16);

        // Write to the address of a single entry that drains in the same cycle.
        cyc(1, 12'h300, 8'h11, 0, 0);
        cyc(1, 12'h300, 8'h22, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Gated drain with writable toggling, then reset in the middle.
        for (int i = 0; i < 5; i++) cyc(1, 12'h400 + ADDR_W'(i), 8'h60 + 8'(i), 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, (i % 2) == 0, 0);
        check("t6_left", q.size(), 2);
        do_reset(1'b1);
        cyc(0, 0, 0, 1, 0);
        check("t6_rst_addr", vram_addr, 0);
        check("t6_rst_data", vram_data, 0);
        cyc(0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
